// File: rtl/cache_pkg.sv
// Shared cache definitions.
// Holds the word/offset geometry used by the cache datapath, the write-policy
// selector, and the record layout of one write-buffer entry in the default
// configuration (12-bit byte address, 32-bit data word).
package cache_pkg;

    localparam int OFFSET_BITS        = 2;   // byte offset within a word
    localparam int BLOCK_SIZE         = 16;  // bytes per cache block
    localparam int DEFAULT_ADDR_BITS  = 12;
    localparam int DEFAULT_DATA_BITS  = 32;
    localparam int WORD_BYTES         = DEFAULT_DATA_BITS / 8;

    typedef enum logic {
        WP_WRITE_BACK    = 1'b0,
        WP_WRITE_THROUGH = 1'b1
    } write_policy_e;

    // One queued store: word address, data, byte enables.
    typedef struct packed {
        logic                                        valid;
        logic [DEFAULT_ADDR_BITS-OFFSET_BITS-1:0]    addr;
        logic [DEFAULT_DATA_BITS-1:0]                data;
        logic [WORD_BYTES-1:0]                       be;
    } wb_entry_t;

endpackage

// File: rtl/cache_wb_forward.sv
// Address match and byte merge for the write buffer.
// Compares every entry against the load address and the store address.
//   Load side : walks entries oldest to youngest starting at the head, so a
//               younger entry overwrites an older one lane by lane.
//               fwd_be = OR of matching byte enables, fwd_hit = |fwd_be.
//   Store side: reports a valid non-head entry with the store address
//               (coalesce target); always 0 when COALESCE = 0.
// Ports: ent_valid/ent_addr/ent_data/ent_be (entry storage), head, rd_addr,
//        wr_addr -> fwd_hit, fwd_data, fwd_be, coal_hit, coal_idx.
module cache_wb_forward #(
    parameter  int WA_BITS   = 10,
    parameter  int DATA_BITS = 32,
    parameter  int DEPTH     = 4,
    parameter  int COALESCE  = 1,
    localparam int BE_BITS   = DATA_BITS / 8,
    localparam int PTR_BITS  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]     ent_valid,
    input  logic [WA_BITS-1:0]   ent_addr [DEPTH],
    input  logic [DATA_BITS-1:0] ent_data [DEPTH],
    input  logic [BE_BITS-1:0]   ent_be   [DEPTH],
    input  logic [PTR_BITS-1:0]  head,
    input  logic [WA_BITS-1:0]   rd_addr,
    input  logic [WA_BITS-1:0]   wr_addr,
    output logic                 fwd_hit,
    output logic [DATA_BITS-1:0] fwd_data,
    output logic [BE_BITS-1:0]   fwd_be,
    output logic                 coal_hit,
    output logic [PTR_BITS-1:0]  coal_idx
);

    logic [DEPTH-1:0]    rd_match;
    logic [DEPTH-1:0]    wr_match;
    logic [PTR_BITS-1:0] idx;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rd_match[i] = ent_valid[i] && (ent_addr[i] == rd_addr);
            wr_match[i] = ent_valid[i] && (ent_addr[i] == wr_addr);
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a value before any condition;
        // a path that leaves one unassigned would infer a latch.
        fwd_data = '0;
        fwd_be   = '0;
        coal_hit = 1'b0;
        coal_idx = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_BITS'(k);
            if (rd_match[idx]) begin
                for (int b = 0; b < BE_BITS; b++) begin
                    if (ent_be[idx][b]) begin
                        fwd_data[8*b +: 8] = ent_data[idx][8*b +: 8];
                        fwd_be[b]          = 1'b1;
                    end
                end
            end
            // k = 0 is the head, which may be mid-transfer to memory.
            if (COALESCE != 0 && k != 0 && wr_match[idx]) begin
                coal_hit = 1'b1;
                coal_idx = idx;
            end
        end
    end

    assign fwd_hit = |fwd_be;

endmodule

// File: rtl/cache_write_buffer.sv
// Write-through store buffer between the data cache and main memory.
// Queues word stores with byte enables in a circular array, drains them to the
// memory write port in order, merges a store into a matching non-head entry,
// and forwards queued bytes to loads.
// Ports:
//   clk, nrst            clock, synchronous active-low reset
//   i_wr_*, o_wr_ready   store request (valid/addr/data/be) and acceptance
//   i_rd_addr, o_fwd_*   load forwarding lookup (hit/data/be)
//   o_mem_*, i_mem_ready head entry presented to memory, popped on ready
//   i_flush, o_flush_done drain request and completion pulse
//   o_count/o_empty/o_full occupancy
module cache_write_buffer
    import cache_pkg::*;
#(
    parameter  int ADDR_BITS = 12,
    parameter  int DATA_BITS = 32,
    parameter  int DEPTH     = 4,
    parameter  int COALESCE  = 1,
    localparam int WA_BITS   = ADDR_BITS - OFFSET_BITS,
    localparam int BE_BITS   = DATA_BITS / 8,
    localparam int CNT_BITS  = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 i_wr_valid,
    input  logic [WA_BITS-1:0]   i_wr_addr,
    input  logic [DATA_BITS-1:0] i_wr_data,
    input  logic [BE_BITS-1:0]   i_wr_be,
    output logic                 o_wr_ready,
    input  logic [WA_BITS-1:0]   i_rd_addr,
    output logic                 o_fwd_hit,
    output logic [DATA_BITS-1:0] o_fwd_data,
    output logic [BE_BITS-1:0]   o_fwd_be,
    output logic                 o_mem_valid,
    output logic [WA_BITS-1:0]   o_mem_addr,
    output logic [DATA_BITS-1:0] o_mem_data,
    output logic [BE_BITS-1:0]   o_mem_be,
    input  logic                 i_mem_ready,
    input  logic                 i_flush,
    output logic                 o_flush_done,
    output logic [CNT_BITS-1:0]  o_count,
    output logic                 o_empty,
    output logic                 o_full
);

    localparam int PTR_BITS = $clog2(DEPTH);

    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [WA_BITS-1:0]   addr_q [DEPTH];
    logic [WA_BITS-1:0]   addr_d [DEPTH];
    logic [DATA_BITS-1:0] data_q [DEPTH];
    logic [DATA_BITS-1:0] data_d [DEPTH];
    logic [BE_BITS-1:0]   be_q   [DEPTH];
    logic [BE_BITS-1:0]   be_d   [DEPTH];
    logic [PTR_BITS-1:0]  head_q, head_d;
    logic [PTR_BITS-1:0]  tail_q, tail_d;
    logic [CNT_BITS-1:0]  count_q, count_d;
    logic                 flushing_q, flushing_d;

    logic                 coal_hit;
    logic [PTR_BITS-1:0]  coal_idx;
    logic                 wr_accept, alloc, merge, pop;

    cache_wb_forward #(
        .WA_BITS   (WA_BITS),
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH),
        .COALESCE  (COALESCE)
    ) u_forward (
        .ent_valid (valid_q),
        .ent_addr  (addr_q),
        .ent_data  (data_q),
        .ent_be    (be_q),
        .head      (head_q),
        .rd_addr   (i_rd_addr),
        .wr_addr   (i_wr_addr),
        .fwd_hit   (o_fwd_hit),
        .fwd_data  (o_fwd_data),
        .fwd_be    (o_fwd_be),
        .coal_hit  (coal_hit),
        .coal_idx  (coal_idx)
    );

    // A full buffer still takes a store that merges into an existing entry;
    // a same-cycle pop never frees a slot for allocation.
    assign o_wr_ready = !flushing_q && ((count_q < CNT_BITS'(DEPTH)) || coal_hit);
    assign wr_accept  = i_wr_valid && o_wr_ready;
    assign merge      = wr_accept && coal_hit;
    assign alloc      = wr_accept && !coal_hit;
    assign pop        = valid_q[head_q] && i_mem_ready;

    assign o_mem_valid  = valid_q[head_q];
    assign o_mem_addr   = addr_q[head_q];
    assign o_mem_data   = data_q[head_q];
    assign o_mem_be     = be_q[head_q];
    assign o_count      = count_q;
    assign o_empty      = (count_q == '0);
    assign o_full       = (count_q == CNT_BITS'(DEPTH));
    assign o_flush_done = flushing_q && (count_q == '0);

    always_comb begin
        valid_d    = valid_q;
        addr_d     = addr_q;
        data_d     = data_q;
        be_d       = be_q;
        head_d     = head_q;
        tail_d     = tail_q;
        flushing_d = flushing_q;

        // Allocation needs count < DEPTH, so tail never equals head while
        // the head is being popped in the same cycle.
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (alloc) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = i_wr_addr;
            data_d[tail_q]  = i_wr_data;
            be_d[tail_q]    = i_wr_be;
            tail_d          = tail_q + 1'b1;
        end
        if (merge) begin
            for (int b = 0; b < BE_BITS; b++) begin
                if (i_wr_be[b]) begin
                    data_d[coal_idx][8*b +: 8] = i_wr_data[8*b +: 8];
                end
            end
            be_d[coal_idx] = be_q[coal_idx] | i_wr_be;
        end
        count_d = count_q + CNT_BITS'(alloc) - CNT_BITS'(pop);

        // Completion wins over a new request; a repeat request is a no-op.
        if (o_flush_done) begin
            flushing_d = 1'b0;
        end else if (i_flush) begin
            flushing_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            flushing_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            flushing_q <= flushing_d;
        end
    end

    // NOTE: the payload array is deliberately not reset; the valid bits alone
    // decide whether an entry is visible, so reset fan-out stays on control.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        be_q   <= be_d;
    end

endmodule

// File: tb/tb_cache_write_buffer.sv
module tb_cache_write_buffer;

    localparam int ADDR_BITS = 12;
    localparam int DATA_BITS = 32;
    localparam int DEPTH     = 4;
    localparam int WA        = ADDR_BITS - 2;
    localparam int BE        = DATA_BITS / 8;
    localparam int CW        = $clog2(DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 nrst = 1'b0;
    logic                 i_wr_valid = 1'b0;
    logic [WA-1:0]        i_wr_addr = '0;
    logic [DATA_BITS-1:0] i_wr_data = '0;
    logic [BE-1:0]        i_wr_be = '0;
    logic                 o_wr_ready;
    logic [WA-1:0]        i_rd_addr = '0;
    logic                 o_fwd_hit;
    logic [DATA_BITS-1:0] o_fwd_data;
    logic [BE-1:0]        o_fwd_be;
    logic                 o_mem_valid;
    logic [WA-1:0]        o_mem_addr;
    logic [DATA_BITS-1:0] o_mem_data;
    logic [BE-1:0]        o_mem_be;
    logic                 i_mem_ready = 1'b0;
    logic                 i_flush = 1'b0;
    logic                 o_flush_done;
    logic [CW-1:0]        o_count;
    logic                 o_empty;
    logic                 o_full;

    always #5 clk = ~clk;

    cache_write_buffer #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH),
        .COALESCE  (1)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .i_wr_valid   (i_wr_valid),
        .i_wr_addr    (i_wr_addr),
        .i_wr_data    (i_wr_data),
        .i_wr_be      (i_wr_be),
        .o_wr_ready   (o_wr_ready),
        .i_rd_addr    (i_rd_addr),
        .o_fwd_hit    (o_fwd_hit),
        .o_fwd_data   (o_fwd_data),
        .o_fwd_be     (o_fwd_be),
        .o_mem_valid  (o_mem_valid),
        .o_mem_addr   (o_mem_addr),
        .o_mem_data   (o_mem_data),
        .o_mem_be     (o_mem_be),
        .i_mem_ready  (i_mem_ready),
        .i_flush      (i_flush),
        .o_flush_done (o_flush_done),
        .o_count      (o_count),
        .o_empty      (o_empty),
        .o_full       (o_full)
    );

    // Reference model: the pending memory writes, oldest first.
    typedef struct {
        logic [WA-1:0]        addr;
        logic [DATA_BITS-1:0] data;
        logic [BE-1:0]        be;
    } ent_t;

    ent_t exp_q[$];
    bit   flushing_m   = 1'b0;
    int   n_checks     = 0;
    int   n_pass       = 0;
    int   flush_pulses = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock cycle with the inputs already driven. At the falling edge the
    // DUT is compared against the model state, then the model takes the
    // store and flush request; pops are handled by the monitor below.
    task automatic step();
        int                   n;
        int                   match;
        bit                   exp_ready;
        bit                   done;
        logic [BE-1:0]        fbe;
        logic [DATA_BITS-1:0] fdat;
        ent_t                 e;
        @(negedge clk);
        if (!nrst) begin
            exp_q.delete();
            flushing_m = 1'b0;
        end else begin
            n     = exp_q.size();
            match = -1;
            for (int i = 1; i < n; i++)
                if (exp_q[i].addr == i_wr_addr) match = i;
            exp_ready = !flushing_m && (n < DEPTH || match >= 0);
            fbe  = '0;
            fdat = '0;
            for (int i = 0; i < n; i++)
                if (exp_q[i].addr == i_rd_addr)
                    for (int b = 0; b < BE; b++)
                        if (exp_q[i].be[b]) begin
                            fdat[8*b +: 8] = exp_q[i].data[8*b +: 8];
                            fbe[b]         = 1'b1;
                        end
            done = flushing_m && (n == 0);
            check("wr_ready",   64'(o_wr_ready),   64'(exp_ready));
            check("count",      64'(o_count),      64'(n));
            check("empty",      64'(o_empty),      64'(n == 0));
            check("full",       64'(o_full),       64'(n == DEPTH));
            check("mem_valid",  64'(o_mem_valid),  64'(n != 0));
            check("flush_done", 64'(o_flush_done), 64'(done));
            check("fwd_hit",    64'(o_fwd_hit),    64'(fbe != '0));
            check("fwd_be",     64'(o_fwd_be),     64'(fbe));
            check("fwd_data",   64'(o_fwd_data),   64'(fdat));
            if (o_flush_done) flush_pulses++;
            flushing_m = done ? 1'b0 : (flushing_m | i_flush);
            if (i_wr_valid && exp_ready) begin
                if (match >= 0) begin
                    e = exp_q[match];
                    for (int b = 0; b < BE; b++)
                        if (i_wr_be[b]) e.data[8*b +: 8] = i_wr_data[8*b +: 8];
                    e.be = e.be | i_wr_be;
                    exp_q[match] = e;
                end else begin
                    e.addr = i_wr_addr;
                    e.data = i_wr_data;
                    e.be   = i_wr_be;
                    exp_q.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted memory write must match the oldest pending one.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #1;
            if (nrst && o_mem_valid && i_mem_ready) begin
                if (exp_q.size() == 0) begin
                    check("mem_unexpected", 64'(o_mem_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("mem_addr", 64'(o_mem_addr), 64'(e.addr));
                    check("mem_data", 64'(o_mem_data), 64'(e.data));
                    check("mem_be",   64'(o_mem_be),   64'(e.be));
                end
            end
        end
    end

    task automatic store(input logic [WA-1:0] a, input logic [DATA_BITS-1:0] d,
                         input logic [BE-1:0] b);
        i_wr_valid = 1'b1;
        i_wr_addr  = a;
        i_wr_data  = d;
        i_wr_be    = b;
        step();
        i_wr_valid = 1'b0;
    endtask

    task automatic drain();
        i_wr_valid  = 1'b0;
        i_flush     = 1'b0;
        i_mem_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        step();
        check("drain_empty", 64'(o_empty), 64'(1));
        i_mem_ready = 1'b0;
    endtask

    initial begin
        // Reset and reset values.
        nrst = 1'b0;
        step();
        step();
        nrst = 1'b1;
        check("rst_wr_ready",  64'(o_wr_ready),  64'(1));
        check("rst_mem_valid", 64'(o_mem_valid), 64'(0));
        check("rst_count",     64'(o_count),     64'(0));
        step();

        // 1: single store, held until memory is ready.
        i_mem_ready = 1'b0;
        store(10'h010, 32'hAABBCCDD, 4'hF);
        check("t1_mem_valid", 64'(o_mem_valid), 64'(1));
        check("t1_mem_addr",  64'(o_mem_addr),  64'(10'h010));
        check("t1_count",     64'(o_count),     64'(1));
        for (int i = 0; i < 3; i++) step();
        check("t1_held_data", 64'(o_mem_data),  64'(32'hAABBCCDD));
        drain();

        // 2: fill, refuse a new address, accept a coalescible store when full.
        for (int i = 1; i <= 4; i++) store(WA'(i), $urandom, 4'hF);
        check("t2_full", 64'(o_full), 64'(1));
        store(10'h005, 32'h5555_5555, 4'hF);
        store(10'h003, 32'h0000_0011, 4'h1);
        check("t2_count", 64'(o_count), 64'(4));
        drain();

        // 3: forwarding merges two stores to the same word behind another head.
        store(10'h040, 32'h1234_5678, 4'hF);
        store(10'h020, 32'h0000_BEEF, 4'h3);
        store(10'h020, 32'h0077_0000, 4'h4);
        i_rd_addr = 10'h020;
        step();
        check("t3_fwd_hit",  64'(o_fwd_hit),  64'(1));
        check("t3_fwd_be",   64'(o_fwd_be),   64'(4'h7));
        check("t3_fwd_data", 64'(o_fwd_data), 64'(32'h0077_BEEF));
        drain();

        // 4: a store matching only the head allocates a new entry.
        store(10'h030, 32'h1234_5678, 4'hF);
        store(10'h030, 32'h9ABC_DEF0, 4'hF);
        check("t4_count",     64'(o_count),    64'(2));
        check("t4_head_data", 64'(o_mem_data), 64'(32'h1234_5678));
        drain();

        // 5: flush with memory ready toggling and stores refused meanwhile.
        for (int i = 0; i < 3; i++) store(WA'(8 + i), $urandom, 4'hF);
        flush_pulses = 0;
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        for (int i = 0; i < 12; i++) begin
            i_mem_ready = 1'(i % 2);
            i_wr_valid  = 1'b1;
            i_wr_addr   = 10'h007;
            i_wr_data   = $urandom;
            i_wr_be     = 4'hF;
            step();
        end
        check("t5_flush_pulses", 64'(flush_pulses), 64'(1));
        drain();

        // 6: reset in the middle of a drain discards the queue.
        store(10'h011, 32'h0101_0101, 4'hF);
        store(10'h012, 32'h0202_0202, 4'hF);
        i_mem_ready = 1'b1;
        step();
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        i_mem_ready = 1'b0;
        check("t6_mem_valid", 64'(o_mem_valid), 64'(0));
        check("t6_count",     64'(o_count),     64'(0));
        check("t6_empty",     64'(o_empty),     64'(1));
        store(10'h3FF, 32'hCAFE_F00D, 4'hF);
        drain();

        // Random traffic on a small address set to exercise coalescing.
        for (int c = 0; c < 1500; c++) begin
            nrst        = ($urandom_range(0, 199) != 0);
            i_wr_valid  = ($urandom_range(0, 9) < 6);
            i_wr_addr   = WA'($urandom_range(0, 5));
            i_wr_data   = $urandom;
            i_wr_be     = BE'($urandom_range(1, 15));
            i_rd_addr   = WA'($urandom_range(0, 5));
            i_mem_ready = 1'($urandom_range(0, 1));
            i_flush     = ($urandom_range(0, 29) == 0);
            step();
        end
        nrst = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_write_buffer.md
Name: cache_write_buffer

Overview:
Parametrised write buffer between the data cache and main memory. It enables a write-through policy as an alternative to the existing write-back eviction path. Core word stores are queued with byte enables and drained to the memory write port in FIFO order. Stores to the same word can be coalesced, and queued data is forwarded to loads so that memory reads never return stale data.

Parameters:
ADDR_BITS, 12, byte-address width; entries hold word address [ADDR_BITS-1:2]
DATA_BITS, 32, data word width; byte-enable width BE_BITS = DATA_BITS/8
DEPTH, 4, number of entries; power of two, minimum 2
COALESCE, 1, 1 = merge a store into a matching non-head entry; 0 = always allocate

Ports:
clk  in  1  clock
nrst  in  1  synchronous active-low reset
i_wr_valid  in  1  core store request
i_wr_addr  in  ADDR_BITS-2  store word address
i_wr_data  in  DATA_BITS  store data, little-endian byte lanes
i_wr_be  in  BE_BITS  store byte enables
o_wr_ready  out  1  store accepted this cycle when high together with i_wr_valid
i_rd_addr  in  ADDR_BITS-2  load word address used for forwarding lookup
o_fwd_hit  out  1  at least one valid entry matches i_rd_addr
o_fwd_data  out  DATA_BITS  merged queued bytes for i_rd_addr
o_fwd_be  out  BE_BITS  lanes of o_fwd_data that are valid
o_mem_valid  out  1  head entry presented to memory
o_mem_addr  out  ADDR_BITS-2  head word address
o_mem_data  out  DATA_BITS  head data
o_mem_be  out  BE_BITS  head byte enables
i_mem_ready  in  1  memory accepts the head this cycle
i_flush  in  1  single-cycle pulse requesting a full drain
o_flush_done  out  1  one-cycle pulse when a requested drain completes
o_count  out  $clog2(DEPTH+1)  occupied entries
o_empty  out  1  o_count == 0
o_full  out  1  o_count == DEPTH

Behaviour:
- Storage: circular array of DEPTH entries {valid, addr, data, be}, plus head/tail pointers ($clog2(DEPTH) bits, natural wrap) and a registered count.
- Reset: all valid bits 0, head = tail = count = 0, flushing = 0.
  - Output reset values: o_mem_valid 0, o_empty 1, o_full 0, o_count 0, o_flush_done 0, o_wr_ready 1, o_fwd_hit 0.
  - Reset mid-drain discards all queued stores; memory sees no further valid.
- Coalesce match: COALESCE=1, a valid entry other than the head has addr == i_wr_addr.
  - On accept, for each lane with be=1, the entry's data lane is overwritten and its be bit is set (be |= i_wr_be).
  - No allocation; count unchanged.
- Allocate: no coalesce match, so write the entry at tail, then tail+1, count+1.
- o_wr_ready = !flushing && (count < DEPTH || coalesce match). A full buffer still accepts coalescible stores.
- Drain: o_mem_* driven combinationally from the head entry; o_mem_valid = head.valid.
  - Pop when o_mem_valid && i_mem_ready: clear head.valid, head+1, count-1.
  - Data held stable while o_mem_valid && !i_mem_ready.
- Head exclusion: the head is never a coalesce target, so an in-flight memory write is never modified. A store matching only the head allocates a new entry.
- Simultaneous allocate and pop: count unchanged; both pointers advance.
- Allocation when full: requires count < DEPTH at the start of the cycle; a same-cycle pop does not free a slot.
- Latency: an allocated store appears on o_mem_valid the next cycle when the buffer was empty (minimum one-cycle enqueue-to-drain).
- Forwarding (combinational):
  - Scan entries oldest to youngest from the head. For each lane, the youngest matching entry with that be bit wins.
  - o_fwd_be = OR of matching be; o_fwd_hit = |o_fwd_be.
  - Lanes with o_fwd_be=0 read 0.
  - The same-cycle incoming store is not forwarded.
- Flush: i_flush sets flushing = 1.
  - When count reaches 0 (or is already 0), o_flush_done pulses for one cycle and flushing clears.
  - A flush while already flushing has no extra effect.
- Pointer wrap: tail/head roll from DEPTH-1 to 0; o_full/o_empty derive from count, never from pointer equality.

Decomposition:
- Shared package cache_pkg: OFFSET_BITS=2, BLOCK_SIZE=16, WORD_BYTES=DATA_BITS/8, write-policy constants (WP_WRITE_BACK, WP_WRITE_THROUGH), entry record layout.
- Sub-module cache_wb_forward: parallel address compare plus youngest-wins per-lane byte merge. Inputs: entry arrays, head pointer, lookup address. Outputs: hit, data, be, and a coalesce-match index/flag. The same comparator serves both i_rd_addr and i_wr_addr.

Test Plan:
1. Reset, then store addr 0x010, data 0xAABBCCDD, be 4'hF with i_mem_ready=0 -> next cycle o_mem_valid=1, o_mem_addr=0x010, o_count=1; data held 3 cycles until ready.
2. DEPTH=4, ready=0, stores to 0x01,0x02,0x03,0x04 -> o_full=1. Store to 0x05 -> o_wr_ready=0. Store 0x03 be 4'h1 data 0x11 -> accepted, count stays 4, entry becomes 0x..11 low lane.
3. Queue 0x20 (be 4'h3, data 0x0000BEEF) then 0x20 (be 4'h4, data 0x00770000) behind a different head; i_rd_addr=0x20 -> o_fwd_hit=1, o_fwd_be=4'h7, o_fwd_data=0x0077BEEF.
4. Head = 0x30 unaccepted, store to 0x30 -> new entry allocated (count 2), head data unchanged; memory receives two writes in order.
5. Three entries queued, pulse i_flush, ready toggling 1/0 -> o_wr_ready=0 throughout; o_flush_done pulses exactly once, the cycle after the final pop.
6. Assert nrst mid-drain with 2 entries -> next cycle o_mem_valid=0, o_count=0, o_empty=1; a following store drains correctly from slot 0.
